// File: rtl/ro_sampler_if.sv
// Word handshake between the RO sampler and the RNG register file.
// master drives data/valid, slave drives ready.
interface ro_sampler_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ro_sampler.sv
// RO entropy sampler: sync, von Neumann extract, pack to words.
// Define RCT_EN to add the repetition-count health test.
module ro_sampler #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int RCT_LIMIT = 32
) (
  input  logic         clk,
  input  logic         res,
  input  logic         en,
  input  logic         ro_in,
  output logic         ro_en,
  ro_sampler_if.master word,
  output logic         overflow,
  output logic         health_fail
);

  localparam int CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BcW  = $clog2(WIDTH);

  typedef enum logic {
    FIRST,
    SECOND
  } ext_state_t;

  if (WIDTH < 2) begin : g_bad_width
    $error("ro_sampler: WIDTH must be >= 2");
  end
  if (DIV < 1) begin : g_bad_div
    $error("ro_sampler: DIV must be >= 1");
  end
  if (RCT_LIMIT < 2) begin : g_bad_rct
    $error("ro_sampler: RCT_LIMIT must be >= 2");
  end

  logic             sync1;
  logic             sync2;
  logic             s;
  logic [CntW-1:0]  pcnt;
  logic             strobe;
  ext_state_t       state;
  ext_state_t       state_nxt;
  logic             a;
  logic             emit;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [BcW-1:0]   bcnt;
  logic             done;
  logic             suppress;
  logic             load;
  logic             drop;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // ro_in is asynchronous; only sync2 may feed logic
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ro_en <= 1'b0;
    end else begin
      ro_en <= en;
    end
  end

  assign strobe = en &&
    (pcnt == CntW'(DIV - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pcnt <= '0;
    end else if (!en || strobe) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= FIRST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    if (!en) begin
      state_nxt = FIRST;
    end else if (strobe) begin
      unique case (1'b1)
        (state == FIRST): begin
          state_nxt = SECOND;
        end
        (state == SECOND): begin
          state_nxt = FIRST;
          emit      = (s != a);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      a <= 1'b0;
    end else if (strobe && state == FIRST) begin
      a <= s;
    end
  end

  // first emitted bit walks down to bit 0
  assign sreg_nxt = {a, sreg[WIDTH-1:1]};
  assign done = emit &&
    (bcnt == BcW'(WIDTH - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sreg <= '0;
      bcnt <= '0;
    end else if (!en) begin
      bcnt <= '0;
    end else if (emit) begin
      sreg <= sreg_nxt;
      bcnt <= done ? '0 : bcnt + 1'b1;
    end
  end

  assign load = done && !suppress &&
    (!valid_q || word.out_ready);
  assign drop = done && !suppress &&
    valid_q && !word.out_ready;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= sreg_nxt;
        valid_q <= 1'b1;
      end else if (valid_q && word.out_ready) begin
        valid_q <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign word.out_data  = data_q;
  assign word.out_valid = valid_q;

`ifdef RCT_EN
  localparam int RunW = $clog2(RCT_LIMIT + 1);

  logic [RunW-1:0] run;
  logic [RunW-1:0] run_nxt;
  logic            last;

  // run==0 means no sample seen since reset or en drop
  always_comb begin
    run_nxt = run;
    if (run == '0 || s != last) begin
      run_nxt = RunW'(1);
    end else if (run != RunW'(RCT_LIMIT)) begin
      run_nxt = run + RunW'(1);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      run         <= '0;
      last        <= 1'b0;
      health_fail <= 1'b0;
    end else if (!en) begin
      run <= '0;
    end else if (strobe) begin
      run  <= run_nxt;
      last <= s;
      if (run_nxt == RunW'(RCT_LIMIT)) begin
        health_fail <= 1'b1;
      end
    end
  end

  assign suppress = health_fail;
`else
  assign health_fail = 1'b0;
  assign suppress    = 1'b0;
`endif

endmodule

// File: tb/tb_ro_sampler.sv
// Bench for ro_sampler: table of raw streams plus corner sequences.
// Expected words go through a queue and are popped on each handshake.
module tb_ro_sampler;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic en = 1'b0;
  logic ro_in = 1'b0;
  logic ro_en;
  logic overflow;
  logic health_fail;

  ro_sampler_if #(.WIDTH(8)) bus ();

  ro_sampler #(
    .WIDTH(8),
    .DIV(1),
    .RCT_LIMIT(32)
  ) dut (
    .clk(clk),
    .res(res),
    .en(en),
    .ro_in(ro_in),
    .ro_en(ro_en),
    .word(bus),
    .overflow(overflow),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] raw;
    int          n;
    bit          has;
    logic [7:0]  w;
  } vec_t;

  vec_t       tbl [7];
  logic [7:0] q [$];
  int         tests = 0;
  int         fails = 0;
  bit         held = 0;
  bit         ovf_exp = 0;
  bit         hf_exp = 0;

  localparam logic [63:0] T2 =
    64'h9A59_0000_0000_0000;
  localparam logic [63:0] ALL1 =
    64'hFFFF_FFFF_FF00_0000;
  localparam logic [63:0] ALL10 =
    64'hAAAA_0000_0000_0000;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // sample i is raw[63-i]; en rises two cycles late
  // so the synchronizer delay lines up with strobes
  task automatic feed(input logic [63:0] raw,
                      input int n);
    for (int i = 0; i < n + 2; i++) begin
      ro_in = (i < n) ? raw[63-i] : 1'b0;
      en = (i >= 2);
      tick(1);
    end
    en = 1'b0;
    ro_in = 1'b0;
    tick(1);
  endtask

  task automatic push_word(input logic [7:0] w);
    if (hf_exp) return;
    if (!held) begin
      q.push_back(w);
      if (!bus.out_ready) held = 1;
    end else begin
      ovf_exp = 1;
    end
  endtask

  always @(negedge clk) begin
    if (!res && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %0h want none",
                 bus.out_data);
      end else begin
        chk("word", {24'h0, bus.out_data},
            {24'h0, q.pop_front()});
      end
    end
  end

  initial begin
    tbl[0] = '{T2, 16, 1'b1, 8'h4D};
    tbl[1] = '{ALL10, 16, 1'b1, 8'hFF};
    tbl[2] = '{64'h5555_0000_0000_0000,
               16, 1'b1, 8'h00};
    tbl[3] = '{64'h2E1D_2D1E_0000_0000,
               32, 1'b1, 8'h93};
    tbl[4] = '{64'h3333_3333_3300_0000,
               40, 1'b0, 8'h00};
    tbl[5] = '{64'h9800_0000_0000_0000,
               6, 1'b0, 8'h00};
    tbl[6] = '{T2, 16, 1'b1, 8'h4D};

    bus.out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_ro_en", 32'(ro_en), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_hf", 32'(health_fail), 0);
    tick(2);
    res = 1'b0;
    tick(2);

    en = 1'b1;
    tick(1);
    chk("ro_en_on", 32'(ro_en), 1);
    en = 1'b0;
    tick(1);
    chk("ro_en_off", 32'(ro_en), 0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].has) push_word(tbl[i].w);
      feed(tbl[i].raw, tbl[i].n);
      tick(3);
      chk($sformatf("v%0d_sb", i), q.size(), 0);
      chk($sformatf("v%0d_valid", i),
          32'(bus.out_valid), 0);
      chk($sformatf("v%0d_ovf", i),
          32'(overflow), 32'(ovf_exp));
    end

    bus.out_ready = 1'b0;
    push_word(8'h4D);
    feed(T2, 16);
    push_word(8'hFF);
    feed(ALL10, 16);
    tick(2);
    chk("stall_ovf", 32'(overflow), 32'(ovf_exp));
    chk("stall_valid", 32'(bus.out_valid), 1);
    chk("stall_data", 32'(bus.out_data), 32'h4D);
    bus.out_ready = 1'b1;
    held = 0;
    tick(3);
    chk("stall_sb", q.size(), 0);
    chk("stall_drain", 32'(bus.out_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    bus.out_ready = 1'b0;
    push_word(8'h4D);
    feed(T2, 16);
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    en = 1'b1;
    #2;
    res = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_data", 32'(bus.out_data), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_ro_en", 32'(ro_en), 0);
    q.delete();
    held = 0;
    ovf_exp = 0;
    en = 1'b0;
    tick(1);
    res = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);
    chk("post_rst_valid", 32'(bus.out_valid), 0);
    push_word(8'h4D);
    feed(T2, 16);
    tick(3);
    chk("post_rst_sb", q.size(), 0);

    feed(ALL1, 40);
    tick(2);
`ifdef RCT_EN
    hf_exp = 1;
    chk("rct_fail", 32'(health_fail), 1);
`else
    chk("rct_none", 32'(health_fail), 0);
`endif
    push_word(8'h4D);
    feed(T2, 16);
    tick(3);
    chk("rct_sb", q.size(), 0);
    chk("rct_valid", 32'(bus.out_valid), 0);
    chk("rct_ovf", 32'(overflow), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
